// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types for the FIR output path.
//   sample_t     : 16-bit signed two's-complement sample as produced by the FIR.
//   ser_state_e  : state encoding for the sample serialiser FSM.
//   FRAME_MSB    : bit-counter value of the first (MSB) bit of a serial frame.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic [3:0] FRAME_MSB = 4'd15;

endpackage : fir_pkg

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO buffering FIR samples ahead of the serialiser.
// A push into a full FIFO is accepted only if a pop happens in the same cycle;
// otherwise it is ignored (the parent flags the drop). Pops on an empty FIFO
// are ignored. rdata always shows the head entry (first-word fall-through).
//
// Ports
//   ck     in   rising-edge clock
//   rst    in   asynchronous active-high reset (pointers and level only)
//   push   in   write wdata this cycle
//   pop    in   discard the head entry this cycle
//   wdata  in   sample to write
//   rdata  out  head-of-queue sample
//   full   out  level == FIFO_DEPTH
//   empty  out  level == 0
//   level  out  current occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module sample_fifo
  import fir_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic signed [15:0]            wdata,
  output logic signed [15:0]            rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  sample_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a push when both happen together.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign rdata = mem[rd_ptr_q];
  assign level = level_q;

  // NOTE: the storage array has no reset; only pointers and level define
  // which entries are valid, so clearing the data would just cost flops.
  always_ff @(posedge ck) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap modulo FIFO_DEPTH by overflowing.
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule : sample_fifo

// File: rtl/sample_serialiser.sv
// -----------------------------------------------------------------------------
// sample_serialiser
// Buffers signed 16-bit FIR samples and shifts them out MSB first as serial
// frames of 16 bits, each bit lasting CLK_DIV ck cycles. Queued samples are
// sent back to back with no idle gap. A sample arriving while the buffer is
// full (and nothing is popped that cycle) is dropped and sets a sticky flag.
//
// Ports
//   ck            in   rising-edge clock
//   rst           in   asynchronous active-high reset; aborts any frame
//   sample_in     in   signed sample, valid with sample_valid
//   sample_valid  in   one-cycle write strobe
//   clr_overflow  in   synchronous clear of overflow (a new drop wins)
//   sclk          out  serial bit clock, low for the first half of each bit
//   sdata         out  serial data, MSB first
//   fsync         out  high for the whole MSB bit period
//   overflow      out  sticky "sample dropped" flag
//   level         out  FIFO occupancy
//   busy          out  high while a frame is shifting
// -----------------------------------------------------------------------------
module sample_serialiser
  import fir_pkg::*;
#(
  parameter int CLK_DIV    = 4,  // even, >= 2
  parameter int FIFO_DEPTH = 4   // power of two
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic signed [15:0]            sample_in,
  input  logic                          sample_valid,
  input  logic                          clr_overflow,
  output logic                          sclk,
  output logic                          sdata,
  output logic                          fsync,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  ser_state_e       state_q;
  sample_t          shreg_q;
  logic [3:0]       bitcnt_q;
  logic [DIV_W-1:0] div_q;
  logic             overflow_q;
  logic             overflow_d;

  sample_t          fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             div_wrap;
  logic             last_bit;
  logic             drop;

  assign div_wrap = (div_q == DIV_LAST);
  assign last_bit = (bitcnt_q == '0);

  // Pop when idle with data waiting, or at the final wrap of a frame so the
  // next frame starts on the very next cycle.
  assign fifo_pop = ~fifo_empty &
                    ((state_q == IDLE) || (div_wrap && last_bit));

  assign drop = sample_valid & fifo_full & ~fifo_pop;

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (sample_valid),
    .pop   (fifo_pop),
    .wdata (sample_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // NOTE: the default assignment first means every path writes overflow_d,
  // so no latch is inferred.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      div_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      unique case (state_q)
        IDLE: begin
          div_q <= '0;
          if (!fifo_empty) begin
            shreg_q  <= fifo_rdata;
            bitcnt_q <= FRAME_MSB;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_wrap) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!last_bit) begin
              shreg_q  <= {shreg_q[14:0], 1'b0};
              bitcnt_q <= bitcnt_q - 4'd1;
            end else if (!fifo_empty) begin
              shreg_q  <= fifo_rdata;
              bitcnt_q <= FRAME_MSB;
            end else begin
              shreg_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; all are forced low outside SHIFT.
  assign busy     = (state_q == SHIFT);
  assign sclk     = busy & (div_q >= DIV_HALF);
  assign sdata    = busy & shreg_q[15];
  assign fsync    = busy & (bitcnt_q == FRAME_MSB);
  assign overflow = overflow_q;

endmodule : sample_serialiser

// File: tb/tb_sample_serialiser.sv
// -----------------------------------------------------------------------------
// tb_sample_serialiser
// Directed bench for sample_serialiser with CLK_DIV=4, FIFO_DEPTH=4.
// Single frames come from a table of {sample, expected bit pattern}; the
// back-to-back, overflow, full push+pop and mid-frame reset cases are written
// out as explicit cycle sequences. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sample_serialiser;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic               ck = 1'b0;
  logic               rst;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               clr_overflow;
  logic               sclk;
  logic               sdata;
  logic               fsync;
  logic               overflow;
  logic [2:0]         level;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic       cap_busy  [0:255];
  logic       cap_sclk  [0:255];
  logic       cap_sdata [0:255];
  logic       cap_fsync [0:255];
  logic [2:0] cap_level [0:255];

  typedef struct {
    string              name;
    logic signed [15:0] smp;
    logic [15:0]        bits;
  } vec_t;

  vec_t vecs [4];

  sample_serialiser #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .ck           (ck),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clr_overflow (clr_overflow),
    .sclk         (sclk),
    .sdata        (sdata),
    .fsync        (fsync),
    .overflow     (overflow),
    .level        (level),
    .busy         (busy)
  );

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to 1ns after the next rising edge (start of a new cycle).
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // One-cycle sample_valid pulse in cycle N; returns in cycle N+1.
  task automatic pulse(input logic signed [15:0] s);
    step();
    sample_valid = 1'b1;
    sample_in    = s;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic capture(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      @(negedge ck);
      cap_busy[c]  = busy;
      cap_sclk[c]  = sclk;
      cap_sdata[c] = sdata;
      cap_fsync[c] = fsync;
      cap_level[c] = level;
    end
  endtask

  // Check one 64-cycle frame starting at capture index s.
  task automatic check_frame(input string tag, input int s,
                             input logic [15:0] exp);
    logic [15:0] w;
    int fs_cnt, busy_cnt, sclk_err, sd_err;
    int k, ph;
    w = '0; fs_cnt = 0; busy_cnt = 0; sclk_err = 0; sd_err = 0;
    for (int c = s; c < s + 16 * CLK_DIV; c++) begin
      k  = (c - s) / CLK_DIV;
      ph = (c - s) % CLK_DIV;
      if (cap_fsync[c]) fs_cnt++;
      if (cap_busy[c]) busy_cnt++;
      if (cap_sclk[c] !== (ph >= CLK_DIV / 2)) sclk_err++;
      if (cap_sdata[c] !== exp[15 - k]) sd_err++;
      if (ph == 1) w[15 - k] = cap_sdata[c];
    end
    check({tag, "_word"}, 32'(w), 32'(exp));
    check({tag, "_fsync_first"}, 32'(cap_fsync[s]), 32'd1);
    check({tag, "_fsync_cnt"}, fs_cnt, 4);
    check({tag, "_busy_cnt"}, busy_cnt, 64);
    check({tag, "_sclk_err"}, sclk_err, 0);
    check({tag, "_sdata_err"}, sd_err, 0);
  endtask

  initial begin
    int idle_err;
    int busy_total;
    int act;

    vecs[0].name = "v8001";  vecs[0].smp = 16'sh8001;  vecs[0].bits = 16'b1000_0000_0000_0001;
    vecs[1].name = "vneg81"; vecs[1].smp = -16'sd81;   vecs[1].bits = 16'b1111_1111_1010_1111;
    vecs[2].name = "v7fff";  vecs[2].smp = 16'sh7FFF;  vecs[2].bits = 16'b0111_1111_1111_1111;
    vecs[3].name = "v5a5a";  vecs[3].smp = 16'sh5A5A;  vecs[3].bits = 16'b0101_1010_0101_1010;

    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    clr_overflow = 1'b0;

    // Reset state.
    repeat (3) @(posedge ck);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sdata", 32'(sdata), 0);
    check("rst_fsync", 32'(fsync), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(level), 0);
    rst = 1'b0;
    repeat (2) step();

    // Single frames from the table.
    for (int i = 0; i < 4; i++) begin
      pulse(vecs[i].smp);
      capture(1, 70);
      check({vecs[i].name, "_lvl_c1"}, 32'(cap_level[1]), 1);
      check({vecs[i].name, "_lvl_c2"}, 32'(cap_level[2]), 0);
      check_frame(vecs[i].name, 2, vecs[i].bits);
      idle_err = 0;
      for (int c = 1; c <= 70; c++) begin
        if ((c < 2 || c > 65) &&
            (cap_busy[c] || cap_sclk[c] || cap_sdata[c] || cap_fsync[c]))
          idle_err++;
      end
      check({vecs[i].name, "_idle_err"}, idle_err, 0);
    end

    // Back-to-back frames: pushes in consecutive cycles.
    step();
    sample_valid = 1'b1;
    sample_in    = 16'sh1234;
    step();
    sample_in    = 16'shFFFF;
    step();
    sample_valid = 1'b0;
    capture(2, 140);
    check_frame("b2b0", 2, 16'h1234);
    check_frame("b2b1", 66, 16'hFFFF);
    busy_total = 0;
    for (int c = 2; c <= 140; c++) if (cap_busy[c]) busy_total++;
    check("b2b_busy_total", busy_total, 128);
    check("b2b_busy_after", 32'(cap_busy[130]), 0);

    // Overflow: six pushes in consecutive cycles M..M+5.
    for (int i = 0; i < 6; i++) begin
      step();
      sample_valid = 1'b1;
      sample_in    = 16'sh1100 + 16'(i);
      @(negedge ck);
      if (i == 1) check("ovf_lvl_m1", 32'(level), 1);
      if (i == 5) begin
        check("ovf_lvl_m5", 32'(level), 4);
        check("ovf_pre", 32'(overflow), 0);
      end
    end
    step();                                  // M+6
    sample_valid = 1'b0;
    @(negedge ck);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_lvl_m6", 32'(level), 4);
    step();                                  // M+7: clear and new drop together
    sample_valid = 1'b1;
    clr_overflow = 1'b1;
    @(negedge ck);
    step();                                  // M+8
    sample_valid = 1'b0;
    clr_overflow = 1'b0;
    @(negedge ck);
    check("ovf_set_wins", 32'(overflow), 1);
    check("ovf_lvl_m8", 32'(level), 4);
    step();                                  // M+9
    clr_overflow = 1'b1;
    @(negedge ck);
    step();                                  // M+10
    clr_overflow = 1'b0;
    @(negedge ck);
    check("ovf_cleared", 32'(overflow), 0);

    // Full FIFO, push in the last cycle of the frame (same cycle as the pop).
    repeat (55) step();                      // M+65
    sample_valid = 1'b1;
    sample_in    = 16'shC3C3;
    @(negedge ck);
    check("pp_lvl_before", 32'(level), 4);
    check("pp_fsync_before", 32'(fsync), 0);
    step();                                  // M+66
    sample_valid = 1'b0;
    @(negedge ck);
    check("pp_lvl_after", 32'(level), 4);
    check("pp_overflow", 32'(overflow), 0);
    check("pp_fsync_after", 32'(fsync), 1);
    check("pp_busy_after", 32'(busy), 1);

    // Mid-frame reset with two samples queued.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;                              // P0
    for (int i = 0; i < 3; i++) begin
      step();                                // P, P+1, P+2
      sample_valid = 1'b1;
      sample_in    = (i == 0) ? 16'sh00FF : 16'sh7E00 + 16'(i);
    end
    step();                                  // P+3
    sample_valid = 1'b0;
    repeat (31) step();                      // P+34: bit counter 7
    @(negedge ck);
    check("mr_busy_pre", 32'(busy), 1);
    check("mr_level_pre", 32'(level), 2);
    check("mr_sdata_pre", 32'(sdata), 1);
    #1;
    rst = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_sclk", 32'(sclk), 0);
    check("mr_sdata", 32'(sdata), 0);
    check("mr_fsync", 32'(fsync), 0);
    check("mr_level", 32'(level), 0);
    step();
    step();
    rst = 1'b0;
    act = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge ck);
      if (busy || sclk || sdata || fsync || (level != 3'd0)) act++;
    end
    check("mr_no_resume", act, 0);

    // A new push after reset produces a normal frame.
    pulse(16'sh4000);
    capture(1, 70);
    check_frame("post_rst", 2, 16'h4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sample_serialiser

// File: doc/sample_serialiser.md
SAMPLE_SERIALISER -- requirements
Module: sample_serialiser

Interface
REQ-001 Parameter CLK_DIV, default 4: ck cycles per serial bit; even, >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer entries; power of two.
REQ-003 Port ck, input, 1: rising-edge clock for all state.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port sample_in, input, 16 signed: filtered sample from the FIR output register.
REQ-006 Port sample_valid, input, 1: one-cycle pulse; sample_in is valid in the same cycle.
REQ-007 Port clr_overflow, input, 1: synchronous clear of overflow.
REQ-008 Port sclk, output, 1: serial bit clock.
REQ-009 Port sdata, output, 1: serial data, MSB first, two's complement.
REQ-010 Port fsync, output, 1: frame sync, high for the MSB bit period.
REQ-011 Port overflow, output, 1: sticky flag for a dropped sample.
REQ-012 Port level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-013 Port busy, output, 1: high whenever a frame is shifting.

Function
REQ-014 A sample_valid cycle with the FIFO not full shall write sample_in into the FIFO at that clock edge.
REQ-015 A sample_valid cycle with the FIFO full and no pop in the same cycle shall drop the sample and set overflow at that edge.
REQ-016 A simultaneous push and pop on a full FIFO shall accept the push, leaving level unchanged.
REQ-017 overflow shall stay set until clr_overflow or rst; if clr_overflow and a new overflow occur together, overflow shall be set.
REQ-018 The FSM shall have exactly two states, IDLE and SHIFT.
REQ-019 In IDLE with level > 0, the FSM shall pop the head into a 16-bit shift register, load the bit counter with 15, clear the divider, and enter SHIFT.
REQ-020 In SHIFT, a divider shall count 0..CLK_DIV-1; sclk shall be 0 for counts below CLK_DIV/2 and 1 otherwise.
REQ-021 sdata shall equal shift-register bit 15 and shall change only when the divider wraps to 0.
REQ-022 fsync shall be high while SHIFT is active and the bit counter is 15.
REQ-023 At divider wrap with bit counter > 0, the shift register shall shift left by one and the bit counter shall decrement.
REQ-024 At divider wrap with bit counter = 0 and level > 0, the FSM shall pop the next sample and stay in SHIFT with no gap.
REQ-025 At divider wrap with bit counter = 0 and level = 0, the FSM shall return to IDLE.
REQ-026 Each frame shall take exactly 16*CLK_DIV ck cycles.
REQ-027 For a sample_valid in cycle N into an empty FIFO with the FSM in IDLE, the MSB shall appear on sdata with fsync high from cycle N+2.
REQ-028 In IDLE, sclk, sdata and fsync shall be 0.
REQ-029 busy shall equal (state == SHIFT).
REQ-030 level shall update in the cycle after each push or pop, with a range of 0..FIFO_DEPTH.
REQ-031 FIFO read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-032 rst shall force IDLE and clear the FIFO pointers, level, overflow, the shift register, the bit counter and the divider.
REQ-033 During reset, sclk, sdata, fsync and busy shall be 0.
REQ-034 rst asserted mid-frame shall abort the frame immediately; the partial frame and buffered samples are discarded, and no frame resumes after reset.

Structure
REQ-035 The shared package fir_pkg shall hold the sample_t typedef (logic signed [15:0]) and the serialiser state enum.
REQ-036 The FIFO shall be a sub-module sample_fifo (parameter FIFO_DEPTH) with push, pop, full, empty and level ports.
REQ-037 The FSM, divider, bit counter and shift register shall reside in sample_serialiser.

Verification
REQ-038 Single sample: push 16'h8001 with CLK_DIV=4 -> sdata 1,0..0,1 over 64 cycles; fsync high cycles 2-5 after valid; busy high for 64 cycles, then IDLE.
REQ-039 Back-to-back frames: push 16'h1234 and 16'hFFFF one cycle apart -> two contiguous 64-cycle frames; fsync at frame starts 64 cycles apart; no IDLE cycle between them.
REQ-040 Overflow: 6 pushes in consecutive cycles, FIFO_DEPTH=4 -> samples 1-5 accepted (1 popped immediately), sample 6 dropped, overflow=1; clr_overflow -> overflow=0.
REQ-041 Full FIFO with push and pop in the same cycle -> push accepted, level stays 4, overflow stays 0.
REQ-042 rst at bit 7 of a frame with 2 samples queued -> all outputs 0 and level 0 the same cycle; no frame after rst release until a new push.
REQ-043 Signed data: push -81 (16'hFFAF) -> sdata bit sequence equals 1111111110101111.
